// File: rtl/counter_pkg.sv
// Shared types and constants for the counter value-bus consumers.
// Holds the shadow-duty and dead-band state encodings.
package counter_pkg;

  localparam int unsigned CNT_WIDTH  = 8;
  localparam int unsigned PCNT_WIDTH = 16;

  typedef enum logic {
    SH_EMPTY,
    SH_PENDING
  } shadow_state_t;

  typedef enum logic [2:0] {
    DB_OFF,
    DB_HI,
    DB_DEAD_HL,
    DB_LO,
    DB_DEAD_LH
  } db_state_t;

endpackage

// File: rtl/pwm_deadband.sv
// Complementary output stage with a dead band of DEADTIME clk cycles
// inserted at every edge of the raw compare signal.
module pwm_deadband
  import counter_pkg::*;
#(
  parameter int unsigned DEADTIME = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic pwm_raw,
  output logic pwm,
  output logic pwm_n
);

  localparam logic [3:0] LP_DT_LAST = 4'(DEADTIME - 1);

  db_state_t  r_state;
  db_state_t  w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_pwm;
  logic       r_pwm_n;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (!enable) begin
      w_next     = DB_OFF;
      w_cnt_next = '0;
    end else begin
      // A raw edge seen inside a dead band restarts the count toward the new side.
      unique case (r_state)
        DB_OFF: begin
          w_next     = pwm_raw ? DB_DEAD_LH : DB_DEAD_HL;
          w_cnt_next = '0;
        end
        DB_HI: begin
          if (!pwm_raw) begin
            w_next     = DB_DEAD_HL;
            w_cnt_next = '0;
          end
        end
        DB_LO: begin
          if (pwm_raw) begin
            w_next     = DB_DEAD_LH;
            w_cnt_next = '0;
          end
        end
        DB_DEAD_HL: begin
          if (pwm_raw) begin
            w_next     = DB_DEAD_LH;
            w_cnt_next = '0;
          end else if (r_cnt == LP_DT_LAST) begin
            w_next = DB_LO;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        DB_DEAD_LH: begin
          if (!pwm_raw) begin
            w_next     = DB_DEAD_HL;
            w_cnt_next = '0;
          end else if (r_cnt == LP_DT_LAST) begin
            w_next = DB_HI;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        default: begin
          w_next     = DB_OFF;
          w_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DB_OFF;
      r_cnt   <= '0;
      r_pwm   <= 1'b0;
      r_pwm_n <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_pwm   <= (w_next == DB_HI);
      r_pwm_n <= (w_next == DB_LO);
    end
  end

  assign pwm   = r_pwm;
  assign pwm_n = r_pwm_n;

endmodule

// File: rtl/counter_pwm_stage.sv
// PWM stage fed by the free-running counter bus; duty changes land only on a wrap.
// Define PWM_DEADTIME_EN for a dead-banded complementary output via pwm_deadband.
module counter_pwm_stage
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH      = CNT_WIDTH,
  parameter int unsigned      DEADTIME   = 4,
  parameter logic [WIDTH-1:0] RESET_DUTY = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_ready,
  input  logic             enable,
  output logic             pwm,
  output logic             pwm_n,
  output logic             wrap,
  output logic [15:0]      period_cnt
);

  if (DEADTIME < 1 || DEADTIME > 15) begin : g_bad_deadtime
    $error("DEADTIME must be in 1..15");
  end

  logic [WIDTH-1:0]      r_prev_value;
  logic [WIDTH-1:0]      r_active_duty;
  logic [WIDTH-1:0]      r_shadow_duty;
  logic [WIDTH-1:0]      w_duty_eff;
  logic [PCNT_WIDTH-1:0] r_period_cnt;
  logic                  r_wrap;
  logic                  w_wrap_evt;
  logic                  w_hs;
  logic                  w_load;
  logic                  w_cmp;
  shadow_state_t         r_sh_state;
  shadow_state_t         w_sh_next;

  // Any drop in value counts as a wrap, including a counter reset mid-count.
  assign w_wrap_evt = (value < r_prev_value);
  assign cfg_ready  = (r_sh_state == SH_EMPTY);
  assign w_hs       = cfg_valid && cfg_ready;
  assign w_load     = (r_sh_state == SH_PENDING) && w_wrap_evt;
  assign w_duty_eff = w_load ? r_shadow_duty : r_active_duty;
  assign w_cmp      = (value < w_duty_eff);

  always_comb begin
    w_sh_next = r_sh_state;
    unique case (r_sh_state)
      SH_EMPTY:   if (w_hs)       w_sh_next = SH_PENDING;
      SH_PENDING: if (w_wrap_evt) w_sh_next = SH_EMPTY;
      default:                    w_sh_next = SH_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_state    <= SH_EMPTY;
      r_prev_value  <= '0;
      r_active_duty <= RESET_DUTY;
      r_shadow_duty <= RESET_DUTY;
      r_wrap        <= 1'b0;
      r_period_cnt  <= '0;
    end else begin
      r_sh_state   <= w_sh_next;
      r_prev_value <= value;
      r_wrap       <= w_wrap_evt;
      if (w_wrap_evt) r_period_cnt <= r_period_cnt + 16'd1;
      if (w_hs)       r_shadow_duty <= cfg_duty;
      if (w_load)     r_active_duty <= r_shadow_duty;
    end
  end

  assign wrap       = r_wrap;
  assign period_cnt = r_period_cnt;

`ifdef PWM_DEADTIME_EN
  pwm_deadband #(
    .DEADTIME (DEADTIME)
  ) u_deadband (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .pwm_raw (w_cmp),
    .pwm     (pwm),
    .pwm_n   (pwm_n)
  );
`else
  logic r_pwm;
  logic r_pwm_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm   <= 1'b0;
      r_pwm_n <= 1'b0;
    end else begin
      r_pwm   <= enable && w_cmp;
      r_pwm_n <= enable && !w_cmp;
    end
  end

  assign pwm   = r_pwm;
  assign pwm_n = r_pwm_n;
`endif

endmodule
